// File: rtl/dma_sequencer.sv
// Purpose: word-by-word DMA between DRAM (byte-addressed) and SRAM (word-addressed), d2s or s2d.
// Latency: DRAM latency + 2 cycles per word; accept cycle is free, stall rises the cycle after accept.
// Backpressure: DRAM requests hold address/data/enable until dramValid; new commands ignored while busy.
// Optional feature: define DMA_BUSY_COUNT_EN to build the busy-cycle counter behind busyCycles.
module dma_sequencer #(
    parameter int SRAM_AW = 14,
    parameter int WIDTH_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         dmaCmd,
    input  logic [31:0]        dmaSrcAddress,
    input  logic [31:0]        dmaDstAddress,
    input  logic [WIDTH_W-1:0] dmaWidth,
    input  logic [31:0]        sramReadData,
    output logic [SRAM_AW-1:0] sramAddress,
    output logic [31:0]        sramWriteData,
    output logic               sramWriteEnable,
    output logic [31:0]        dramAddress,
    output logic [31:0]        dramWriteData,
    output logic               dramWriteEnable,
    output logic               dramReadEnable,
    input  logic [31:0]        dramReadData,
    input  logic               dramValid,
    output logic               stall,
    output logic [31:0]        busyCycles
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DRD  = 3'd1,
        SWR  = 3'd2,
        SRD  = 3'd3,
        DWR  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_D2S = 2'b01;
    localparam logic [1:0] CMD_S2D = 2'b10;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] i_q, i_d;
    logic               dir_s2d_q, dir_s2d_d;
    logic [31:0]        data_q, data_d;

    // Word index after the current word completes; the transfer ends when it reaches the width.
    logic [WIDTH_W-1:0] i_next;
    logic               last_word;
    // Per-word address offsets: SRAM wraps at 2^SRAM_AW words, DRAM at 2^32 bytes.
    logic [SRAM_AW-1:0] i_sram;
    logic [31:0]        i_bytes;

    // Index arithmetic shared by every state.
    always_comb begin
        i_next    = i_q + WIDTH_W'(1);
        last_word = (i_next == width_q);
        i_sram    = SRAM_AW'(i_q);
        i_bytes   = 32'(i_q) << 2;
    end

    // Next-state and output decode; every output defaults to 0 so IDLE drives nothing.
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        width_d         = width_q;
        i_d             = i_q;
        dir_s2d_d       = dir_s2d_q;
        data_d          = data_q;
        sramAddress     = '0;
        sramWriteData   = '0;
        sramWriteEnable = 1'b0;
        dramAddress     = '0;
        dramWriteData   = '0;
        dramWriteEnable = 1'b0;
        dramReadEnable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only a real direction with a non-zero length starts a transfer.
                if ((dmaCmd == CMD_D2S || dmaCmd == CMD_S2D) && dmaWidth != '0) begin
                    src_d     = dmaSrcAddress;
                    dst_d     = dmaDstAddress;
                    width_d   = dmaWidth;
                    dir_s2d_d = (dmaCmd == CMD_S2D);
                    i_d       = '0;
                    state_d   = (dmaCmd == CMD_S2D) ? SRD : DRD;
                end
            end
            DRD: begin
                dramReadEnable = 1'b1;
                dramAddress    = src_q + i_bytes;
                if (dramValid) begin
                    data_d  = dramReadData;
                    state_d = SWR;
                end
            end
            SWR: begin
                sramWriteEnable = 1'b1;
                sramAddress     = dst_q[SRAM_AW+1:2] + i_sram;
                sramWriteData   = data_q;
                i_d             = i_next;
                state_d         = last_word ? IDLE : DRD;
            end
            SRD: begin
                // The SRAM returns the word while its address is held; it is registered on exit.
                sramAddress = src_q[SRAM_AW+1:2] + i_sram;
                data_d      = sramReadData;
                state_d     = DWR;
            end
            DWR: begin
                dramWriteEnable = 1'b1;
                dramAddress     = dst_q + i_bytes;
                dramWriteData   = data_q;
                if (dramValid) begin
                    i_d     = i_next;
                    state_d = last_word ? IDLE : SRD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall comes from the registered state only, so it never depends on the incoming command.
    always_comb begin
        stall = (state_q != IDLE);
    end

    // State and transfer-context registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            width_q   <= '0;
            i_q       <= '0;
            dir_s2d_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            width_q   <= width_d;
            i_q       <= i_d;
            dir_s2d_q <= dir_s2d_d;
            data_q    <= data_d;
        end
    end

    // Direction is kept for observability of the active transfer; the state encodes the path.
    logic unused_dir;
    always_comb begin
        unused_dir = dir_s2d_q;
    end

`ifdef DMA_BUSY_COUNT_EN
    logic [31:0] busy_q, busy_d;

    // Count every stalled cycle, wrapping naturally at 2^32.
    always_comb begin
        busy_d = stall ? (busy_q + 32'd1) : busy_q;
    end

    // Busy counter register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busyCycles = busy_q;
`else
    assign busyCycles = '0;
`endif

endmodule

// File: tb/tb_dma_sequencer.sv
module tb_dma_sequencer;

    localparam int LAT = 2;  // DRAM answers on the LAT-th cycle after the request starts

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        clk;
    logic        reset;
    logic [1:0]  dmaCmd;
    logic [31:0] dmaSrcAddress;
    logic [31:0] dmaDstAddress;
    logic [9:0]  dmaWidth;
    logic [31:0] sramReadData;
    logic [13:0] sramAddress;
    logic [31:0] sramWriteData;
    logic        sramWriteEnable;
    logic [31:0] dramAddress;
    logic [31:0] dramWriteData;
    logic        dramWriteEnable;
    logic        dramReadEnable;
    logic [31:0] dramReadData;
    logic        dramValid;
    logic        stall;
    logic [31:0] busyCycles;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic stray_vld = 1'b0;

    xfer_t sram_q[$];   // expected SRAM writes
    xfer_t dwr_q[$];    // expected DRAM writes
    xfer_t rd_q[$];     // expected DRAM reads with the data the model returns

    logic [31:0] mem [0:16383];

    dma_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .dmaCmd          (dmaCmd),
        .dmaSrcAddress   (dmaSrcAddress),
        .dmaDstAddress   (dmaDstAddress),
        .dmaWidth        (dmaWidth),
        .sramReadData    (sramReadData),
        .sramAddress     (sramAddress),
        .sramWriteData   (sramWriteData),
        .sramWriteEnable (sramWriteEnable),
        .dramAddress     (dramAddress),
        .dramWriteData   (dramWriteData),
        .dramWriteEnable (dramWriteEnable),
        .dramReadEnable  (dramReadEnable),
        .dramReadData    (dramReadData),
        .dramValid       (dramValid),
        .stall           (stall),
        .busyCycles      (busyCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM returns the addressed word within the cycle the address is held.
    assign sramReadData = mem[sramAddress];

    // Monitor and DRAM model, both working on the falling edge away from DUT updates.
    always @(negedge clk) begin
        xfer_t e;
        logic fire;
        fire = (dramReadEnable || dramWriteEnable) && (req_cnt == LAT);
        if (stall) stall_cnt++;
        if (!stall) begin
            total++;
            if ({sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
                 dramWriteEnable, dramReadEnable} !== '0) begin
                bad++;
                $display("FAIL idle_outputs: sa=%h sd=%h swe=%b da=%h dd=%h dwe=%b dre=%b want all 0",
                         sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
                         dramWriteEnable, dramReadEnable);
            end
        end
        if (sramWriteEnable) begin
            total++;
            if (sram_q.size() == 0) begin
                bad++;
                $display("FAIL sram_write: unexpected write addr=%h data=%h", sramAddress, sramWriteData);
            end else begin
                e = sram_q.pop_front();
                if (sramAddress !== e.addr[13:0] || sramWriteData !== e.data) begin
                    bad++;
                    $display("FAIL sram_write: got addr=%h data=%h want addr=%h data=%h",
                             sramAddress, sramWriteData, e.addr[13:0], e.data);
                end
            end
        end
        if (dramWriteEnable) begin
            total++;
            if (dwr_q.size() == 0) begin
                bad++;
                $display("FAIL dram_write: unexpected write addr=%h data=%h", dramAddress, dramWriteData);
            end else begin
                e = dwr_q[0];
                if (dramAddress !== e.addr || dramWriteData !== e.data) begin
                    bad++;
                    $display("FAIL dram_write: got addr=%h data=%h want addr=%h data=%h",
                             dramAddress, dramWriteData, e.addr, e.data);
                end
                if (fire) void'(dwr_q.pop_front());
            end
        end
        if (dramReadEnable) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL dram_read: unexpected read addr=%h", dramAddress);
            end else begin
                e = rd_q[0];
                if (dramAddress !== e.addr) begin
                    bad++;
                    $display("FAIL dram_read: got addr=%h want addr=%h", dramAddress, e.addr);
                end
                dramReadData = e.data;
                if (fire) void'(rd_q.pop_front());
            end
        end
        if (dramReadEnable || dramWriteEnable) begin
            dramValid = fire;
            req_cnt   = fire ? 0 : req_cnt + 1;
        end else begin
            dramValid = stray_vld;
            req_cnt   = 0;
        end
    end

    task automatic issue(input logic [1:0] cmd, input logic [31:0] s, input logic [31:0] d,
                         input logic [9:0] w);
        @(posedge clk); #1;
        dmaCmd = cmd; dmaSrcAddress = s; dmaDstAddress = d; dmaWidth = w;
        @(posedge clk); #1;
        dmaCmd = 2'b00; dmaSrcAddress = '0; dmaDstAddress = '0; dmaWidth = '0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            if (!stall) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: stall=%b want 0 within 300 cycles", name, stall);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sram_q.size() != 0 || dwr_q.size() != 0 || rd_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: pending sram=%0d dwr=%0d rd=%0d want 0 0 0",
                     name, sram_q.size(), dwr_q.size(), rd_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total++;
        if (stall !== 1'b0 || busyCycles !== 32'd0 || dramReadEnable !== 1'b0 || sramWriteEnable !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: stall=%b busy=%0d dre=%b swe=%b want 0 0 0 0",
                     stall, busyCycles, dramReadEnable, sramWriteEnable);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_d2s();
        logic [31:0] want_busy;
        for (int k = 0; k < 3; k++) begin
            rd_q.push_back('{32'h100 + 32'(4 * k), 32'hA0 + 32'(k)});
            sram_q.push_back('{32'h10 + 32'(k), 32'hA0 + 32'(k)});
        end
        stall_cnt = 0;
        @(posedge clk); #1;
        dmaCmd = 2'b01; dmaSrcAddress = 32'h100; dmaDstAddress = 32'h40; dmaWidth = 10'd3;
        #2;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL accept_stall: stall=%b want 0 in accept cycle", stall);
        end
        @(posedge clk); #1;
        dmaCmd = 2'b00; dmaWidth = '0;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_rise: stall=%b want 1 after accept", stall);
        end
        wait_idle("d2s");
        total++;
        if (stall_cnt != 12) begin
            bad++;
            $display("FAIL d2s_stall_cycles: got %0d want 12", stall_cnt);
        end
`ifdef DMA_BUSY_COUNT_EN
        want_busy = 32'd12;
`else
        want_busy = 32'd0;
`endif
        total++;
        if (busyCycles !== want_busy) begin
            bad++;
            $display("FAIL busy_cycles: got %0d want %0d", busyCycles, want_busy);
        end
        check_drained("d2s");
    endtask

    task automatic test_s2d();
        mem[0] = 32'hDEAD;
        mem[1] = 32'hBEEF;
        dwr_q.push_back('{32'h2000, 32'hDEAD});
        dwr_q.push_back('{32'h2004, 32'hBEEF});
        stall_cnt = 0;
        issue(2'b10, 32'h0, 32'h2000, 10'd2);
        wait_idle("s2d");
        total++;
        if (stall_cnt != 2 * (LAT + 2)) begin
            bad++;
            $display("FAIL s2d_stall_cycles: got %0d want %0d", stall_cnt, 2 * (LAT + 2));
        end
        check_drained("s2d");
    endtask

    task automatic test_ignored();
        stall_cnt = 0;
        stray_vld = 1'b1;
        @(posedge clk); #1;
        dmaCmd = 2'b01; dmaSrcAddress = 32'h100; dmaDstAddress = 32'h40; dmaWidth = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        dmaCmd = 2'b11; dmaWidth = 10'd4;
        repeat (2) @(posedge clk);
        #1;
        dmaCmd = 2'b00; dmaWidth = '0;
        stray_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (stall_cnt != 0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL ignored_cmds: stall_cycles=%0d stall=%b want 0 0", stall_cnt, stall);
        end
        check_drained("ignored");
    endtask

    task automatic test_back_to_back();
        rd_q.push_back('{32'h300, 32'h55});
        sram_q.push_back('{32'h40, 32'h55});
        mem[2] = 32'h77;
        dwr_q.push_back('{32'h4000, 32'h77});
        stall_cnt = 0;
        issue(2'b01, 32'h300, 32'h100, 10'd1);
        dmaCmd = 2'b10; dmaSrcAddress = 32'h8; dmaDstAddress = 32'h9000; dmaWidth = 10'd5;
        @(posedge clk); #1;
        dmaCmd = 2'b00; dmaSrcAddress = '0; dmaDstAddress = '0; dmaWidth = '0;
        wait_idle("b2b_first");
        issue(2'b10, 32'h8, 32'h4000, 10'd1);
        wait_idle("b2b_second");
        total++;
        if (stall_cnt != 2 * (LAT + 2)) begin
            bad++;
            $display("FAIL b2b_stall_cycles: got %0d want %0d", stall_cnt, 2 * (LAT + 2));
        end
        check_drained("b2b");
    endtask

    task automatic test_wrap();
        rd_q.push_back('{32'hFFFF_FFFC, 32'h1111});
        rd_q.push_back('{32'h0000_0000, 32'h2222});
        sram_q.push_back('{32'h3FFF, 32'h1111});
        sram_q.push_back('{32'h0000, 32'h2222});
        issue(2'b01, 32'hFFFF_FFFC, 32'hFFFC, 10'd2);
        wait_idle("wrap");
        check_drained("wrap");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        for (int k = 0; k < 4; k++) rd_q.push_back('{32'h200 + 32'(4 * k), 32'hC0 + 32'(k)});
        sram_q.push_back('{32'h20, 32'hC0});
        issue(2'b01, 32'h200, 32'h80, 10'd4);
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            if (sram_q.size() == 0) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_mid_first_word: first SRAM write not seen within 50 cycles");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || dramReadEnable !== 1'b0 || dramAddress !== 32'd0 || busyCycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: stall=%b dre=%b da=%h busy=%0d want 0 0 0 0",
                     stall, dramReadEnable, dramAddress, busyCycles);
        end
        rd_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stall_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (stall_cnt != 0) begin
            bad++;
            $display("FAIL reset_mid_no_resume: stall_cycles=%0d want 0", stall_cnt);
        end
        rd_q.push_back('{32'h500, 32'h99});
        sram_q.push_back('{32'h7, 32'h99});
        issue(2'b01, 32'h500, 32'h1C, 10'd1);
        wait_idle("after_reset");
        check_drained("after_reset");
    endtask

    initial begin
        dmaCmd = 2'b00; dmaSrcAddress = '0; dmaDstAddress = '0; dmaWidth = '0;
        dramValid = 1'b0; dramReadData = '0;
        for (int k = 0; k < 16384; k++) mem[k] = 32'h0;
        test_reset();
        test_d2s();
        test_s2d();
        test_ignored();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
